// File: rtl/bb_pkg.sv
// rtl/bb_pkg.sv - shared types and helpers for the Blackbone round-robin bus
package bb_pkg;

  localparam int MAX_AW = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    HOLD
  } state_e;

  // A disabled slave never matches, whatever its mask/base say.
  function automatic logic range_match(input logic [MAX_AW-1:0] addr,
                                       input logic [MAX_AW-1:0] mask,
                                       input logic [MAX_AW-1:0] base,
                                       input logic              en);
    return en && ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/bb_bus_rr_if.sv
// rtl/bb_bus_rr_if.sv - master/slave side signal bundle of the Blackbone bus
interface bb_bus_rr_if #(
  parameter int MASTERS    = 2,
  parameter int SLAVES     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] m_din_i;
  logic [MASTERS-1:0]                 m_en_i;
  logic [MASTERS-1:0]                 m_we_i;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dout_o;
  logic [MASTERS-1:0]                 m_ack_o;
  logic [MASTERS-1:0]                 m_err_o;
  logic [SLAVES-1:0][ADDR_WIDTH-1:0]  s_addr_o;
  logic [SLAVES-1:0][DATA_WIDTH-1:0]  s_din_o;
  logic [SLAVES-1:0]                  s_en_o;
  logic [SLAVES-1:0]                  s_we_o;
  logic [SLAVES-1:0][DATA_WIDTH-1:0]  s_dout_i;
  logic [ADDR_WIDTH-1:0]              snoop_adr_o;
  logic                               snoop_en_o;
  logic                               bus_hold;
  logic                               bus_hold_ack;

  // Interconnect view.
  modport slave (
    input  m_addr_i, m_din_i, m_en_i, m_we_i, s_dout_i, bus_hold,
    output m_dout_o, m_ack_o, m_err_o, s_addr_o, s_din_o, s_en_o, s_we_o,
           snoop_adr_o, snoop_en_o, bus_hold_ack
  );

  // Environment view: masters, slaves and the hold requester.
  modport master (
    output m_addr_i, m_din_i, m_en_i, m_we_i, s_dout_i, bus_hold,
    input  m_dout_o, m_ack_o, m_err_o, s_addr_o, s_din_o, s_en_o, s_we_o,
           snoop_adr_o, snoop_en_o, bus_hold_ack
  );
endinterface

// File: rtl/bb_rr_arbiter.sv
// rtl/bb_rr_arbiter.sv - round-robin arbiter, search starts after the last grant
module bb_rr_arbiter #(
  parameter int N = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N-1:0]                       req_i,
  input  logic                               advance_i,
  output logic [N-1:0]                       grant_onehot_o,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_idx_o,
  output logic                               valid_o
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] idx;
  logic          found;
  logic [IW:0]   cand;

  // cand never exceeds 2N-1, so one extra bit holds the unreduced sum.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

  assign valid_o        = found;
  assign grant_idx_o    = idx;
  assign grant_onehot_o = found ? (N'(1) << idx) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IW'(N-1);
    else if (advance_i && found) last_q <= idx;
  end
endmodule

// File: rtl/bb_bus_rr.sv
// rtl/bb_bus_rr.sv - pipelined Blackbone interconnect: RR arbitration, range
// decode, decode-miss error, write snoop and bus-hold handshake
module bb_bus_rr
  import bb_pkg::*;
#(
  parameter int                               MASTERS      = 2,
  parameter int                               SLAVES       = 2,
  parameter int                               DATA_WIDTH   = 32,
  parameter int                               ADDR_WIDTH   = 32,
  parameter logic [SLAVES-1:0]                S_ENABLE     = '1,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_RANGE_MASK = '0,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_RANGE_BASE = '0
) (
  input logic         clk_i,
  input logic         rst_i,
  bb_bus_rr_if.slave  bus
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  state_e                             state_q, state_d;
  logic [MW-1:0]                      grant_q, grant_d;
  logic [MASTERS-1:0]                 gnt_oh_q, gnt_oh_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]              din_q, din_d;
  logic                               we_q, we_d;
  logic [SW-1:0]                      sel_q, sel_d;
  logic                               hit_q, hit_d;
  logic [SLAVES-1:0]                  s_en_q, s_en_d;
  logic [MASTERS-1:0][DATA_WIDTH-1:0] dout_q, dout_d;

  logic [MASTERS-1:0] arb_req, arb_oh;
  logic [MW-1:0]      arb_idx;
  logic               arb_valid, arb_adv;
  logic               dec_hit;
  logic [SW-1:0]      dec_sel;
  logic [DATA_WIDTH-1:0] resp_data;
  logic               take;
  logic               snoop_en;

  // In RESP the master just served is excluded from the next search.
  assign arb_req = (state_q == RESP) ? (bus.m_en_i & ~gnt_oh_q) : bus.m_en_i;

  bb_rr_arbiter #(.N(MASTERS)) u_arb (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (arb_req),
    .advance_i      (arb_adv),
    .grant_onehot_o (arb_oh),
    .grant_idx_o    (arb_idx),
    .valid_o        (arb_valid)
  );

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = SLAVES-1; i >= 0; i--) begin
      if (range_match(MAX_AW'(bus.m_addr_i[arb_idx]), MAX_AW'(S_RANGE_MASK[i]),
                      MAX_AW'(S_RANGE_BASE[i]), S_ENABLE[i])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign resp_data = hit_q ? bus.s_dout_i[sel_q] : '0;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    sel_d    = sel_q;
    hit_d    = hit_q;
    s_en_d   = '0;
    dout_d   = dout_q;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_hold) state_d = HOLD;
        else if (arb_valid) take = 1'b1;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        dout_d[grant_q] = resp_data;
        if (bus.bus_hold) state_d = HOLD;
        else if (arb_valid) take = 1'b1;
        else state_d = IDLE;
      end
      HOLD: begin
        if (!bus.bus_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d  = ACCESS;
      grant_d  = arb_idx;
      gnt_oh_d = arb_oh;
      addr_d   = bus.m_addr_i[arb_idx];
      din_d    = bus.m_din_i[arb_idx];
      we_d     = bus.m_we_i[arb_idx];
      sel_d    = dec_sel;
      hit_d    = dec_hit;
      s_en_d   = dec_hit ? (SLAVES'(1) << dec_sel) : '0;
    end
    arb_adv = take;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      hit_q    <= 1'b0;
      s_en_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      hit_q    <= hit_d;
      s_en_q   <= s_en_d;
      dout_q   <= dout_d;
    end
  end

  // Read data is shown live in RESP and held in dout_q afterwards.
  always_comb begin
    bus.m_dout_o = dout_q;
    if (state_q == RESP) bus.m_dout_o[grant_q] = resp_data;
  end

  assign snoop_en         = (state_q == RESP) && hit_q && we_q;
  assign bus.m_ack_o      = (state_q == RESP && hit_q) ? gnt_oh_q : '0;
  assign bus.m_err_o      = (state_q == RESP && !hit_q) ? gnt_oh_q : '0;
  assign bus.s_addr_o     = {SLAVES{addr_q}};
  assign bus.s_din_o      = {SLAVES{din_q}};
  assign bus.s_we_o       = {SLAVES{we_q}};
  assign bus.s_en_o       = s_en_q;
  assign bus.snoop_en_o   = snoop_en;
  assign bus.snoop_adr_o  = snoop_en ? addr_q : '0;
  assign bus.bus_hold_ack = (state_q == HOLD);
endmodule

// File: tb/tb_bb_bus_rr.sv
// tb/tb_bb_bus_rr.sv - directed self-checking bench for bb_bus_rr
module tb_bb_bus_rr;
  localparam logic [1:0][31:0] MASK   = {32'hF000_0000, 32'hF000_0000};
  localparam logic [1:0][31:0] BASE   = {32'h1000_0000, 32'h0000_0000};
  localparam logic [1:0][31:0] SLV_RD = {32'hCAFE_F00D, 32'h5A5A_0000};

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;
  logic [1:0] exp_ack [1:8];
  logic [1:0] exp_sen [1:8];

  always #5 clk = ~clk;

  bb_bus_rr_if #(.MASTERS(2), .SLAVES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  bb_bus_rr #(
    .MASTERS(2), .SLAVES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .S_ENABLE(2'b11), .S_RANGE_MASK(MASK), .S_RANGE_BASE(BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Synchronous-read slaves, one cycle latency, fixed read data per slave.
  always @(posedge clk) begin
    if (rst) bus.s_dout_i <= '0;
    else for (int i = 0; i < 2; i++) if (bus.s_en_o[i]) bus.s_dout_i[i] <= SLV_RD[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.m_addr_i = '0; bus.m_din_i = '0; bus.m_en_i = '0; bus.m_we_i = '0;
    bus.bus_hold = 1'b0;
    exp_ack = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_sen = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    repeat (2) nxt();
    check("rst_ack", bus.m_ack_o, 0);
    check("rst_err", bus.m_err_o, 0);
    check("rst_sen", bus.s_en_o, 0);
    check("rst_saddr", bus.s_addr_o, 0);
    check("rst_hack", bus.bus_hold_ack, 0);
    check("rst_snoop", bus.snoop_en_o, 0);
    check("rst_dout", bus.m_dout_o, 0);
    rst = 1'b0;
    nxt();

    // Read: master 0 -> slave 1
    bus.m_addr_i[0] = 32'h1000_0040; bus.m_we_i[0] = 1'b0; bus.m_en_i[0] = 1'b1;
    nxt();
    check("rd_sen", bus.s_en_o, 2'b10);
    check("rd_saddr", bus.s_addr_o[1], 32'h1000_0040);
    check("rd_ack_early", bus.m_ack_o, 0);
    nxt();
    check("rd_ack", bus.m_ack_o, 2'b01);
    check("rd_err", bus.m_err_o, 0);
    check("rd_dout", bus.m_dout_o[0], 32'hCAFE_F00D);
    check("rd_snoop", bus.snoop_en_o, 0);
    bus.m_en_i[0] = 1'b0;
    nxt();
    check("rd_ack_gone", bus.m_ack_o, 0);
    check("rd_dout_hold", bus.m_dout_o[0], 32'hCAFE_F00D);

    // Write snoop: master 1 -> slave 0
    bus.m_addr_i[1] = 32'h0000_0010; bus.m_din_i[1] = 32'hDEAD_BEEF;
    bus.m_we_i[1] = 1'b1; bus.m_en_i[1] = 1'b1;
    nxt();
    check("wr_sen", bus.s_en_o, 2'b01);
    check("wr_swe", bus.s_we_o, 2'b11);
    check("wr_sdin", bus.s_din_o[0], 32'hDEAD_BEEF);
    nxt();
    check("wr_ack", bus.m_ack_o, 2'b10);
    check("wr_snoop", bus.snoop_en_o, 1);
    check("wr_snoop_adr", bus.snoop_adr_o, 32'h0000_0010);
    bus.m_en_i[1] = 1'b0; bus.m_we_i[1] = 1'b0;
    nxt();
    check("wr_snoop_gone", bus.snoop_en_o, 0);

    // Decode miss: master 0 writes an unmapped address
    bus.m_addr_i[0] = 32'hF000_0000; bus.m_din_i[0] = 32'h1;
    bus.m_we_i[0] = 1'b1; bus.m_en_i[0] = 1'b1;
    nxt();
    check("miss_sen", bus.s_en_o, 0);
    nxt();
    check("miss_err", bus.m_err_o, 2'b01);
    check("miss_ack", bus.m_ack_o, 0);
    check("miss_snoop", bus.snoop_en_o, 0);
    check("miss_dout", bus.m_dout_o[0], 0);
    bus.m_en_i[0] = 1'b0; bus.m_we_i[0] = 1'b0;
    nxt();
    check("miss_err_gone", bus.m_err_o, 0);

    // Arbitration: both masters request continuously (last grant was 0)
    bus.m_addr_i[0] = 32'h1000_0000; bus.m_addr_i[1] = 32'h0000_0004;
    bus.m_en_i = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      check($sformatf("arb_ack%0d", k), bus.m_ack_o, exp_ack[k]);
      check($sformatf("arb_sen%0d", k), bus.s_en_o, exp_sen[k]);
    end
    check("arb_dout0", bus.m_dout_o[0], 32'hCAFE_F00D);
    check("arb_dout1", bus.m_dout_o[1], 32'h5A5A_0000);
    bus.m_en_i = 2'b00;
    nxt();

    // Hold raised during ACCESS
    bus.m_en_i[0] = 1'b1;
    nxt();
    bus.bus_hold = 1'b1;
    check("hold_sen", bus.s_en_o, 2'b10);
    nxt();
    check("hold_ack_done", bus.m_ack_o, 2'b01);
    check("hold_hack0", bus.bus_hold_ack, 0);
    bus.m_en_i[0] = 1'b0;
    bus.m_addr_i[1] = 32'h0000_0008; bus.m_en_i[1] = 1'b1;
    nxt();
    check("hold_hack1", bus.bus_hold_ack, 1);
    check("hold_nogrant1", bus.s_en_o, 0);
    nxt();
    check("hold_hack2", bus.bus_hold_ack, 1);
    check("hold_nogrant2", bus.s_en_o, 0);
    bus.bus_hold = 1'b0;
    nxt();
    check("hold_release", bus.bus_hold_ack, 0);
    check("hold_idle_sen", bus.s_en_o, 0);
    nxt();
    check("hold_grant", bus.s_en_o, 2'b01);
    nxt();
    check("hold_grant_ack", bus.m_ack_o, 2'b10);
    bus.m_en_i[1] = 1'b0;
    nxt();

    // Reset mid-access (last grant is 1)
    bus.m_addr_i[0] = 32'h1000_0000; bus.m_en_i[0] = 1'b1;
    nxt();
    check("rma_sen", bus.s_en_o, 2'b10);
    rst = 1'b1; bus.m_en_i = 2'b00;
    nxt();
    check("rma_ack", bus.m_ack_o, 0);
    check("rma_err", bus.m_err_o, 0);
    check("rma_sen0", bus.s_en_o, 0);
    check("rma_dout", bus.m_dout_o, 0);
    check("rma_hack", bus.bus_hold_ack, 0);
    check("rma_snoop", bus.snoop_en_o, 0);
    rst = 1'b0;
    bus.m_addr_i[1] = 32'h0000_0004; bus.m_en_i = 2'b11;
    nxt();
    check("rma_first_grant", bus.s_en_o, 2'b10);
    nxt();
    check("rma_first_ack", bus.m_ack_o, 2'b01);
    bus.m_en_i = 2'b00;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/bb_bus_rr.md
# bb_bus_rr

Pipelined Blackbone bus interconnect connecting MASTERS masters to SLAVES slaves. It provides:
- round-robin arbitration;
- mask/base address decode held in parameter arrays, with any slave count;
- a decode-miss error response;
- a registered write-snoop port;
- a bus-hold handshake.

It is the parametrised successor to the single-cycle mux+decode bus. Every slave is a synchronous-read memory-like target with one cycle of read latency.

## Interface
- MASTERS, 2, number of masters (≥1)
- SLAVES, 2, number of slaves (≥1)
- DATA_WIDTH, 32, data width in bits, multiple of 8
- ADDR_WIDTH, 32, address width in bits
- S_ENABLE, all ones, [SLAVES-1:0] per-slave enable; a disabled slave never matches
- S_RANGE_MASK, all zeros, [SLAVES-1:0][ADDR_WIDTH-1:0] address bits compared
- S_RANGE_BASE, all zeros, [SLAVES-1:0][ADDR_WIDTH-1:0] required value of masked bits

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-high
- m_addr_i  in  [MASTERS-1:0][ADDR_WIDTH-1:0]  master address
- m_din_i  in  [MASTERS-1:0][DATA_WIDTH-1:0]  master write data
- m_en_i  in  [MASTERS-1:0]  request; held until ack/err
- m_we_i  in  [MASTERS-1:0]  1 = write
- m_dout_o  out  [MASTERS-1:0][DATA_WIDTH-1:0]  read data, valid with ack
- m_ack_o  out  [MASTERS-1:0]  one-cycle completion pulse
- m_err_o  out  [MASTERS-1:0]  one-cycle decode-miss pulse
- s_addr_o  out  [SLAVES-1:0][ADDR_WIDTH-1:0]  captured address, broadcast
- s_din_o  out  [SLAVES-1:0][DATA_WIDTH-1:0]  captured write data, broadcast
- s_en_o  out  [SLAVES-1:0]  one-hot (or zero) slave strobe
- s_we_o  out  [SLAVES-1:0]  captured write enable, broadcast
- s_dout_i  in  [SLAVES-1:0][DATA_WIDTH-1:0]  slave read data, valid one cycle after s_en_o
- snoop_adr_o  out  ADDR_WIDTH  address of the completed write
- snoop_en_o  out  1  one-cycle pulse per successful write
- bus_hold  in  1  request to freeze the bus
- bus_hold_ack  out  1  bus frozen

## Operation

**State machine (states IDLE, ACCESS, RESP, HOLD).**
- **IDLE**
  - If bus_hold=1, go to HOLD.
  - Else, if any m_en_i bit is set, register the grant, the winner's addr/din/we and the decoded slave index, then go to ACCESS.
- **ACCESS**
  - Drive s_en_o for the decoded slave and go to RESP.
  - On a decode miss, s_en_o stays 0.
- **RESP**
  - Register s_dout_i of the accessed slave into m_dout_o[grant].
  - Pulse m_ack_o[grant], or on a miss pulse m_err_o[grant] with m_dout_o[grant]=0.
  - Next state:
    - bus_hold=1 → HOLD;
    - else a new request, arbitrated over m_en_i & ~onehot(grant) → ACCESS;
    - else → IDLE.
- **HOLD**
  - bus_hold_ack=1, and no grants are issued.
  - When bus_hold=0, go to IDLE; bus_hold_ack drops with the state change.

**Arbitration**
- Round-robin with the search starting at last_grant+1, modulo MASTERS. The pointer updates only on a grant.
- After reset, last_grant = MASTERS-1, so master 0 wins first.

**Decode**
- Slave i matches when S_ENABLE[i] and (addr & S_RANGE_MASK[i]) == S_RANGE_BASE[i].
- If several slaves match, the lowest index wins.

**Snoop**
- In RESP of a successful write, snoop_en_o=1 and snoop_adr_o = the captured address.
- Reads and decode misses never snoop.

**Master contract and boundary cases**
- m_dout_o[k] holds its value until master k's next response.
- If a master drops m_en_i mid-access, the access still completes and the ack is still pulsed.
- bus_hold asserted during ACCESS or RESP: the in-flight access finishes first, then the bus enters HOLD.
- Reset mid-access: all state is cleared on the next edge; no ack or err is issued.

## Timing
- **Reset values:** every output is 0; state is IDLE.
- **Latency:** m_en_i high at edge T → s_en_o high in cycle T+1 → m_ack_o/m_err_o and m_dout_o valid in cycle T+2.
- **Throughput:** back-to-back grants give one access per 2 cycles.
- **Hold timing:**
  - bus_hold_ack rises 1 cycle after the hold is sampled in IDLE, or after the completing RESP.
  - bus_hold_ack falls 1 cycle after bus_hold falls.
- **Register boundaries:** s_* outputs are driven from registers only. Nothing passes combinationally from m_* inputs to s_* outputs.

## Structure
- Package bb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, HOLD);
  - a range-match function (addr, mask, base, enable).
- Sub-module bb_rr_arbiter #(N), with ports req, advance, grant_onehot, grant_idx, valid. It is reusable by other interconnects.

## Test plan
- **Read:** S_RANGE_MASK[1]=32'hF000_0000, S_RANGE_BASE[1]=32'h1000_0000; master 0 reads 32'h1000_0040 and slave 1 returns 32'hCAFE_F00D → s_en_o=2'b10 at T+1, m_ack_o[0]=1 and m_dout_o[0]=32'hCAFE_F00D at T+2, snoop_en_o=0.
- **Arbitration:** both masters request continuously → grants alternate 0,1,0,1; acks arrive every 2 cycles.
- **Decode miss:** write to 32'hF000_0000 with no slave matching → s_en_o never set, m_err_o pulses, snoop_en_o=0.
- **Write snoop:** master 1 writes 32'h0000_0010 to slave 0 → snoop_en_o=1 with snoop_adr_o=32'h0000_0010 in the same cycle as m_ack_o[1].
- **Hold during access:** bus_hold raised during ACCESS → the ack still completes; bus_hold_ack rises the next cycle; a pending m_en_i is not granted until 1 cycle after bus_hold falls.
- **Reset mid-access:** rst_i asserted in ACCESS → no ack or err pulse; all outputs are 0 the next cycle; the first grant after reset goes to master 0.
